// File: rtl/picorv32_pcpi_pkg.sv
`default_nettype none
// ============================================================================
// Module   : picorv32_pcpi_pkg
// Brief    : Shared PCPI encodings: opcode/funct7/funct3 and FSM states
// Revision : 1.0 - initial release
// ============================================================================
package picorv32_pcpi_pkg;

    localparam logic [6:0] c_OPCODE_OP     = 7'b0110011;
    localparam logic [6:0] c_FUNCT7_MULDIV = 7'b0000001;

    localparam logic [2:0] c_F3_MUL    = 3'b000;
    localparam logic [2:0] c_F3_MULH   = 3'b001;
    localparam logic [2:0] c_F3_MULHSU = 3'b010;
    localparam logic [2:0] c_F3_MULHU  = 3'b011;
    localparam logic [2:0] c_F3_DIV    = 3'b100;
    localparam logic [2:0] c_F3_DIVU   = 3'b101;
    localparam logic [2:0] c_F3_REM    = 3'b110;
    localparam logic [2:0] c_F3_REMU   = 3'b111;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_MUL   = 3'd1,
        ST_DIV   = 3'd2,
        ST_FIX   = 3'd3,
        ST_DONE  = 3'd4,
        ST_GUARD = 3'd5
    } pcpi_state_t;

endpackage
`default_nettype wire

// File: rtl/picorv32_pcpi_csa_step.sv
`default_nettype none
// ============================================================================
// Module   : picorv32_pcpi_csa_step
// Brief    : One carry-save accumulate step: (o_rd + o_rdx) = i_rd + i_rdx + i_addend
// Revision : 1.0 - initial release
// ============================================================================
module picorv32_pcpi_csa_step #(
    parameter int CARRY_CHAIN = 4,
    parameter int WIDTH       = 64
) (
    input  logic [WIDTH-1:0] i_rd,
    input  logic [WIDTH-1:0] i_rdx,
    input  logic [WIDTH-1:0] i_addend,
    output logic [WIDTH-1:0] o_rd,
    output logic [WIDTH-1:0] o_rdx
);

    if (CARRY_CHAIN == 0) begin : g_csa
        assign o_rd  = i_rd ^ i_rdx ^ i_addend;
        assign o_rdx = ((i_rd & i_rdx) | (i_rd & i_addend) | (i_rdx & i_addend)) << 1;
    end else begin : g_chain
        localparam int c_SEGS = WIDTH / CARRY_CHAIN;

        logic [c_SEGS-1:0] w_cout;
        logic              w_unused;

        // rdx only ever holds a single carry bit at the base of each segment
        for (genvar s = 0; s < c_SEGS; s++) begin : g_seg
            logic [CARRY_CHAIN:0] w_sum;
            assign w_sum = (CARRY_CHAIN+1)'(i_rd[s*CARRY_CHAIN +: CARRY_CHAIN])
                         + (CARRY_CHAIN+1)'(i_addend[s*CARRY_CHAIN +: CARRY_CHAIN])
                         + (CARRY_CHAIN+1)'(i_rdx[s*CARRY_CHAIN]);
            assign o_rd[s*CARRY_CHAIN +: CARRY_CHAIN] = w_sum[CARRY_CHAIN-1:0];
            assign w_cout[s] = w_sum[CARRY_CHAIN];
        end

        always_comb begin
            o_rdx = '0;
            for (int s = 0; s < c_SEGS - 1; s++) begin
                o_rdx[(s+1)*CARRY_CHAIN] = w_cout[s];
            end
        end

        assign w_unused = ^{w_cout[c_SEGS-1], i_rdx};
    end

endmodule
`default_nettype wire

// File: rtl/picorv32_pcpi_muldiv.sv
`default_nettype none
// ============================================================================
// Module   : picorv32_pcpi_muldiv
// Brief    : PCPI co-processor for RV32M multiply (carry-save) and divide (restoring)
// Revision : 1.0 - initial release
// ============================================================================
module picorv32_pcpi_muldiv #(
    parameter int STEPS_AT_ONCE = 1,
    parameter int CARRY_CHAIN   = 4,
    parameter bit ENABLE_DIV    = 1'b1
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        pcpi_valid,
    input  logic [31:0] pcpi_insn,
    input  logic [31:0] pcpi_rs1,
    input  logic [31:0] pcpi_rs2,
    output logic        pcpi_wr,
    output logic [31:0] pcpi_rd,
    output logic        pcpi_wait,
    output logic        pcpi_ready
);
    import picorv32_pcpi_pkg::*;

    pcpi_state_t r_state, w_state_n;
    logic [2:0]  r_funct3, w_funct3_n;
    logic [63:0] r_rs1, w_rs1_n, r_rs2, w_rs2_n;
    logic [63:0] r_rd, w_rd_n, r_rdx, w_rdx_n;
    logic [6:0]  r_count, w_count_n;
    logic        r_neg_q, w_neg_q_n, r_neg_r, w_neg_r_n;
    logic        w_wr_n, w_ready_n, w_wait_n;
    logic [31:0] w_pcpi_rd_n;

    // ---------------- request decode ----------------
    logic [2:0]  w_f3;
    logic        w_claim, w_s1, w_s2, w_div_signed, w_is_rem_in;
    logic        w_neg1, w_neg2, w_div_zero, w_div_ovf;
    logic [31:0] w_mag1, w_mag2, w_special_rd;
    logic        w_unused_insn;

    assign w_f3    = pcpi_insn[14:12];
    assign w_claim = pcpi_valid && (pcpi_insn[6:0] == c_OPCODE_OP)
                  && (pcpi_insn[31:25] == c_FUNCT7_MULDIV) && (!w_f3[2] || ENABLE_DIV);
    assign w_unused_insn = ^{pcpi_insn[24:15], pcpi_insn[11:7]};

    assign w_s1         = (w_f3 == c_F3_MULH) || (w_f3 == c_F3_MULHSU);
    assign w_s2         = (w_f3 == c_F3_MULH);
    assign w_div_signed = !((w_f3 == c_F3_DIVU) || (w_f3 == c_F3_REMU));
    assign w_is_rem_in  = (w_f3 == c_F3_REM) || (w_f3 == c_F3_REMU);
    assign w_neg1       = w_div_signed && pcpi_rs1[31];
    assign w_neg2       = w_div_signed && pcpi_rs2[31];
    assign w_mag1       = w_neg1 ? -pcpi_rs1 : pcpi_rs1;
    assign w_mag2       = w_neg2 ? -pcpi_rs2 : pcpi_rs2;
    assign w_div_zero   = (pcpi_rs2 == 32'd0);
    assign w_div_ovf    = w_div_signed && (pcpi_rs1 == 32'h8000_0000) && (pcpi_rs2 == 32'hFFFF_FFFF);
    assign w_special_rd = w_is_rem_in ? (w_div_zero ? pcpi_rs1 : 32'd0)
                                      : (w_div_zero ? 32'hFFFF_FFFF : 32'h8000_0000);

    // ---------------- multiplier carry-save chain ----------------
    logic [63:0] w_rd_chain  [STEPS_AT_ONCE+1];
    logic [63:0] w_rdx_chain [STEPS_AT_ONCE+1];
    logic [63:0] w_addend    [STEPS_AT_ONCE];

    assign w_rd_chain[0]  = r_rd;
    assign w_rdx_chain[0] = r_rdx;

    for (genvar i = 0; i < STEPS_AT_ONCE; i++) begin : g_step
        assign w_addend[i] = r_rs1[i] ? (r_rs2 << i) : 64'd0;
        picorv32_pcpi_csa_step #(
            .CARRY_CHAIN (CARRY_CHAIN),
            .WIDTH       (64)
        ) u_step (
            .i_rd     (w_rd_chain[i]),
            .i_rdx    (w_rdx_chain[i]),
            .i_addend (w_addend[i]),
            .o_rd     (w_rd_chain[i+1]),
            .o_rdx    (w_rdx_chain[i+1])
        );
    end

    // ---------------- final resolve ----------------
    logic [63:0] w_prod;
    logic [31:0] w_quot, w_rem, w_fix_rd;

    assign w_prod   = r_rd + r_rdx;
    assign w_quot   = r_neg_q ? -r_rd[31:0]  : r_rd[31:0];
    assign w_rem    = r_neg_r ? -r_rs1[31:0] : r_rs1[31:0];
    assign w_fix_rd = !r_funct3[2] ? ((r_funct3 == c_F3_MUL) ? w_prod[31:0] : w_prod[63:32])
                    : (((r_funct3 == c_F3_REM) || (r_funct3 == c_F3_REMU)) ? w_rem : w_quot);

    // ---------------- FSM / datapath next state ----------------
    always_comb begin
        w_state_n   = r_state;
        w_funct3_n  = r_funct3;
        w_rs1_n     = r_rs1;
        w_rs2_n     = r_rs2;
        w_rd_n      = r_rd;
        w_rdx_n     = r_rdx;
        w_count_n   = r_count;
        w_neg_q_n   = r_neg_q;
        w_neg_r_n   = r_neg_r;
        w_wr_n      = 1'b0;
        w_ready_n   = 1'b0;
        w_wait_n    = 1'b0;
        w_pcpi_rd_n = pcpi_rd;

        case (r_state)
            ST_IDLE: begin
                if (w_claim) begin
                    w_funct3_n = w_f3;
                    w_wait_n   = 1'b1;
                    w_rd_n     = 64'd0;
                    w_rdx_n    = 64'd0;
                    if (!w_f3[2]) begin
                        w_rs1_n   = w_s1 ? {{32{pcpi_rs1[31]}}, pcpi_rs1} : {32'd0, pcpi_rs1};
                        w_rs2_n   = w_s2 ? {{32{pcpi_rs2[31]}}, pcpi_rs2} : {32'd0, pcpi_rs2};
                        w_count_n = (w_f3 == c_F3_MUL) ? 7'(32 / STEPS_AT_ONCE) : 7'(64 / STEPS_AT_ONCE);
                        w_state_n = ST_MUL;
                    end else if (w_div_zero || w_div_ovf) begin
                        w_rd_n    = {32'd0, w_special_rd};
                        w_state_n = ST_DONE;
                    end else begin
                        w_rs1_n   = {32'd0, w_mag1};
                        w_rs2_n   = {1'b0, w_mag2, 31'd0};
                        w_neg_q_n = w_neg1 ^ w_neg2;
                        w_neg_r_n = w_neg1;
                        w_count_n = 7'd32;
                        w_state_n = ST_DIV;
                    end
                end
            end
            ST_MUL: begin
                if (!pcpi_valid) begin
                    w_state_n = ST_IDLE;
                end else begin
                    w_wait_n  = 1'b1;
                    w_rd_n    = w_rd_chain[STEPS_AT_ONCE];
                    w_rdx_n   = w_rdx_chain[STEPS_AT_ONCE];
                    w_rs1_n   = r_rs1 >> STEPS_AT_ONCE;
                    w_rs2_n   = r_rs2 << STEPS_AT_ONCE;
                    w_count_n = r_count - 7'd1;
                    if (r_count == 7'd1) w_state_n = ST_FIX;
                end
            end
            ST_DIV: begin
                if (!pcpi_valid) begin
                    w_state_n = ST_IDLE;
                end else begin
                    w_wait_n = 1'b1;
                    if (r_rs2 <= r_rs1) begin
                        w_rs1_n = r_rs1 - r_rs2;
                        w_rd_n  = {r_rd[62:0], 1'b1};
                    end else begin
                        w_rd_n  = {r_rd[62:0], 1'b0};
                    end
                    w_rs2_n   = r_rs2 >> 1;
                    w_count_n = r_count - 7'd1;
                    if (r_count == 7'd1) w_state_n = ST_FIX;
                end
            end
            ST_FIX: begin
                if (!pcpi_valid) begin
                    w_state_n = ST_IDLE;
                end else begin
                    w_ready_n   = 1'b1;
                    w_wr_n      = 1'b1;
                    w_pcpi_rd_n = w_fix_rd;
                    w_state_n   = ST_DONE;
                end
            end
            ST_DONE: begin
                // special-case divides arrive here directly and answer one cycle later
                if (!pcpi_ready) begin
                    w_ready_n   = 1'b1;
                    w_wr_n      = 1'b1;
                    w_pcpi_rd_n = r_rd[31:0];
                end else begin
                    w_state_n = ST_GUARD;
                end
            end
            ST_GUARD: w_state_n = ST_IDLE;
            default:  w_state_n = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_state    <= ST_IDLE;
            r_funct3   <= 3'd0;
            r_rs1      <= 64'd0;
            r_rs2      <= 64'd0;
            r_rd       <= 64'd0;
            r_rdx      <= 64'd0;
            r_count    <= 7'd0;
            r_neg_q    <= 1'b0;
            r_neg_r    <= 1'b0;
            pcpi_wr    <= 1'b0;
            pcpi_ready <= 1'b0;
            pcpi_wait  <= 1'b0;
            pcpi_rd    <= 32'd0;
        end else begin
            r_state    <= w_state_n;
            r_funct3   <= w_funct3_n;
            r_rs1      <= w_rs1_n;
            r_rs2      <= w_rs2_n;
            r_rd       <= w_rd_n;
            r_rdx      <= w_rdx_n;
            r_count    <= w_count_n;
            r_neg_q    <= w_neg_q_n;
            r_neg_r    <= w_neg_r_n;
            pcpi_wr    <= w_wr_n;
            pcpi_ready <= w_ready_n;
            pcpi_wait  <= w_wait_n;
            pcpi_rd    <= w_pcpi_rd_n;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_picorv32_pcpi_muldiv.sv
`default_nettype none
// ============================================================================
// Module   : tb_picorv32_pcpi_muldiv
// Brief    : Directed self-checking bench for the PCPI mul/div co-processor
// Revision : 1.0 - initial release
// ============================================================================
module tb_picorv32_pcpi_muldiv;

    localparam logic [6:0] c_F7 = 7'b0000001;

    logic        clk = 1'b0;
    logic        resetn;
    logic        valid [3];
    logic [31:0] insn, rs1, rs2;
    logic        wr_w [3];
    logic        wait_w [3];
    logic        ready_w [3];
    logic [31:0] rd_w [3];

    int checks;
    int errors;

    always #5 clk = ~clk;

    picorv32_pcpi_muldiv dut0 (
        .clk(clk), .resetn(resetn), .pcpi_valid(valid[0]), .pcpi_insn(insn),
        .pcpi_rs1(rs1), .pcpi_rs2(rs2), .pcpi_wr(wr_w[0]), .pcpi_rd(rd_w[0]),
        .pcpi_wait(wait_w[0]), .pcpi_ready(ready_w[0])
    );

    picorv32_pcpi_muldiv #(.STEPS_AT_ONCE(4), .CARRY_CHAIN(8), .ENABLE_DIV(1'b1)) dut1 (
        .clk(clk), .resetn(resetn), .pcpi_valid(valid[1]), .pcpi_insn(insn),
        .pcpi_rs1(rs1), .pcpi_rs2(rs2), .pcpi_wr(wr_w[1]), .pcpi_rd(rd_w[1]),
        .pcpi_wait(wait_w[1]), .pcpi_ready(ready_w[1])
    );

    picorv32_pcpi_muldiv #(.STEPS_AT_ONCE(1), .CARRY_CHAIN(0), .ENABLE_DIV(1'b0)) dut2 (
        .clk(clk), .resetn(resetn), .pcpi_valid(valid[2]), .pcpi_insn(insn),
        .pcpi_rs1(rs1), .pcpi_rs2(rs2), .pcpi_wr(wr_w[2]), .pcpi_rd(rd_w[2]),
        .pcpi_wait(wait_w[2]), .pcpi_ready(ready_w[2])
    );

    function automatic logic [31:0] mk(input logic [6:0] f7, input logic [2:0] f3);
        return {f7, 5'd2, 5'd1, f3, 5'd3, 7'b0110011};
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Issue one op, hold valid until ready (bounded), then release and let GUARD pass.
    task automatic run_op(input int d, input logic [31:0] i, input logic [31:0] a,
                          input logic [31:0] b, input int exp_lat,
                          input logic [31:0] exp_rd, input string tag);
        int   lat;
        logic proto_ok;
        insn = i; rs1 = a; rs2 = b; valid[d] = 1'b1;
        lat = 0;
        proto_ok = 1'b1;
        for (int k = 1; k <= 200 && lat == 0; k++) begin
            @(posedge clk); #1;
            if (ready_w[d]) lat = k;
            else if (wait_w[d] !== 1'b1) proto_ok = 1'b0;
            if (wr_w[d] !== ready_w[d]) proto_ok = 1'b0;
        end
        chk({tag, " latency"}, 32'(lat), 32'(exp_lat));
        chk({tag, " rd"}, rd_w[d], exp_rd);
        chk({tag, " wait/wr protocol"}, {31'd0, proto_ok}, 32'd1);
        chk({tag, " wait in response"}, {31'd0, wait_w[d]}, 32'd0);
        valid[d] = 1'b0;
        @(posedge clk); #1;
        chk({tag, " single ready"}, {31'd0, ready_w[d] | wr_w[d]}, 32'd0);
        chk({tag, " rd hold"}, rd_w[d], exp_rd);
        @(posedge clk); #1;
    endtask

    task automatic quiet(input int d, input int cycles, input string tag);
        logic seen;
        seen = 1'b0;
        for (int k = 0; k < cycles; k++) begin
            @(posedge clk); #1;
            if (ready_w[d] || wr_w[d] || wait_w[d]) seen = 1'b1;
        end
        chk(tag, {31'd0, seen}, 32'd0);
    endtask

    initial begin
        checks = 0; errors = 0;
        resetn = 1'b0;
        for (int k = 0; k < 3; k++) valid[k] = 1'b0;
        insn = 32'd0; rs1 = 32'd0; rs2 = 32'd0;
        repeat (3) @(posedge clk);
        #1;
        chk("reset rd",    rd_w[0], 32'd0);
        chk("reset ready", {31'd0, ready_w[0]}, 32'd0);
        chk("reset wr",    {31'd0, wr_w[0]}, 32'd0);
        chk("reset wait",  {31'd0, wait_w[0]}, 32'd0);
        resetn = 1'b1;

        // multiply, one bit per cycle
        run_op(0, mk(c_F7, 3'b000), 32'h0000_0007, 32'hFFFF_FFFD, 34, 32'hFFFF_FFEB, "MUL s1");
        run_op(0, mk(c_F7, 3'b001), 32'h8000_0000, 32'h8000_0000, 66, 32'h4000_0000, "MULH s1");
        run_op(0, mk(c_F7, 3'b011), 32'hFFFF_FFFF, 32'hFFFF_FFFF, 66, 32'hFFFF_FFFE, "MULHU s1");
        run_op(0, mk(c_F7, 3'b010), 32'hFFFF_FFFF, 32'hFFFF_FFFF, 66, 32'hFFFF_FFFF, "MULHSU s1");

        // four bits per cycle
        run_op(1, mk(c_F7, 3'b000), 32'h0000_0007, 32'hFFFF_FFFD, 10, 32'hFFFF_FFEB, "MUL s4");
        run_op(1, mk(c_F7, 3'b001), 32'h8000_0000, 32'h8000_0000, 18, 32'h4000_0000, "MULH s4");
        run_op(1, mk(c_F7, 3'b010), 32'hFFFF_FFFF, 32'hFFFF_FFFF, 18, 32'hFFFF_FFFF, "MULHSU s4");

        // pure carry-save variant
        run_op(2, mk(c_F7, 3'b000), 32'h0001_0001, 32'h0001_0001, 34, 32'h0002_0001, "MUL csa");
        run_op(2, mk(c_F7, 3'b011), 32'h0001_0001, 32'h0001_0001, 66, 32'h0000_0001, "MULHU csa");

        // divide
        run_op(0, mk(c_F7, 3'b100), 32'hFFFF_FFF9, 32'h0000_0002, 34, 32'hFFFF_FFFD, "DIV neg");
        run_op(0, mk(c_F7, 3'b110), 32'hFFFF_FFF9, 32'h0000_0002, 34, 32'hFFFF_FFFF, "REM neg");
        run_op(0, mk(c_F7, 3'b111), 32'd100, 32'd7, 34, 32'd2, "REMU");
        run_op(0, mk(c_F7, 3'b101), 32'h8000_0000, 32'hFFFF_FFFF, 34, 32'd0, "DIVU big");
        run_op(0, mk(c_F7, 3'b111), 32'h8000_0000, 32'hFFFF_FFFF, 34, 32'h8000_0000, "REMU big");

        // special cases
        run_op(0, mk(c_F7, 3'b101), 32'd5, 32'd0, 2, 32'hFFFF_FFFF, "DIVU by zero");
        run_op(0, mk(c_F7, 3'b110), 32'd5, 32'd0, 2, 32'd5, "REM by zero");
        run_op(0, mk(c_F7, 3'b100), 32'h8000_0000, 32'hFFFF_FFFF, 2, 32'h8000_0000, "DIV ovf");
        run_op(0, mk(c_F7, 3'b110), 32'h8000_0000, 32'hFFFF_FFFF, 2, 32'd0, "REM ovf");

        // abort a divide at A+5
        insn = mk(c_F7, 3'b100); rs1 = 32'd100; rs2 = 32'd7; valid[0] = 1'b1;
        repeat (5) begin @(posedge clk); #1; end
        chk("abort wait A+5", {31'd0, wait_w[0]}, 32'd1);
        valid[0] = 1'b0;
        @(posedge clk); #1;
        chk("abort wait A+6", {31'd0, wait_w[0]}, 32'd0);
        quiet(0, 40, "abort no response");
        run_op(0, mk(c_F7, 3'b101), 32'd100, 32'd7, 34, 32'd14, "DIVU after abort");

        // reset in the middle of a MULH
        insn = mk(c_F7, 3'b001); rs1 = 32'h8000_0000; rs2 = 32'h8000_0000; valid[0] = 1'b1;
        repeat (10) begin @(posedge clk); #1; end
        chk("mid-op wait", {31'd0, wait_w[0]}, 32'd1);
        resetn = 1'b0;
        #1;
        chk("async reset rd",    rd_w[0], 32'd0);
        chk("async reset wait",  {31'd0, wait_w[0]}, 32'd0);
        chk("async reset ready", {31'd0, ready_w[0]}, 32'd0);
        valid[0] = 1'b0;
        @(posedge clk); #1;
        resetn = 1'b1;
        quiet(0, 80, "post-reset no response");
        resetn = 1'b0;
        @(posedge clk); #1;
        resetn = 1'b1;
        run_op(0, mk(c_F7, 3'b000), 32'd3, 32'd4, 34, 32'd12, "MUL after reset");

        // unclaimed instructions
        insn = mk(7'b0000000, 3'b000); rs1 = 32'd1; rs2 = 32'd2; valid[0] = 1'b1;
        quiet(0, 100, "ADD not claimed");
        valid[0] = 1'b0;
        insn = mk(c_F7, 3'b100); rs1 = 32'd100; rs2 = 32'd7; valid[2] = 1'b1;
        quiet(2, 100, "DIV not claimed no-div");
        valid[2] = 1'b0;
        @(posedge clk); #1;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
